// File: rtl/f1_xgmii_frame_mon.sv
// Passive monitor for a 32-bit XGMII stream: delimits frames by Start/Terminate,
// flags length/framing errors and keeps good/bad/byte statistics.
module f1_xgmii_frame_mon #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        I_pla_312m5_clk,
  input  logic        I_pla_rst,
  input  logic [31:0] I_xgmii_d,
  input  logic [3:0]  I_xgmii_c,
  input  logic        I_stat_clr,
  output logic        O_frame_done,
  output logic [15:0] O_frame_len,
  output logic        O_frame_err,
  output logic [31:0] O_good_cnt,
  output logic [31:0] O_bad_cnt,
  output logic [31:0] O_byte_cnt
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} state_t;

  state_t      state;
  logic [15:0] len;
  logic        err_sticky;

  logic        is_start;
  logic        is_sfd;
  logic        is_data;
  logic        is_term;
  logic [2:0]  term_k;
  logic [15:0] len_term;
  logic [15:0] len_word;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic len_bad(input logic [15:0] l);
    return (l < MIN_L) || (l > MAX_L);
  endfunction

  always_comb begin
    is_start = (I_xgmii_c == 4'b1000) && (I_xgmii_d[31:24] == 8'hFB);
    is_data  = (I_xgmii_c == 4'b0000);
    is_sfd   = is_data && (I_xgmii_d == 32'h555555D5);
    is_term  = 1'b0;
    term_k   = 3'd0;
    if (I_xgmii_c == 4'b1111 && I_xgmii_d[31:24] == 8'hFD) begin
      is_term = 1'b1;
      term_k  = 3'd0;
    end else if (I_xgmii_c == 4'b0111 && I_xgmii_d[23:16] == 8'hFD) begin
      is_term = 1'b1;
      term_k  = 3'd1;
    end else if (I_xgmii_c == 4'b0011 && I_xgmii_d[15:8] == 8'hFD) begin
      is_term = 1'b1;
      term_k  = 3'd2;
    end else if (I_xgmii_c == 4'b0001 && I_xgmii_d[7:0] == 8'hFD) begin
      is_term = 1'b1;
      term_k  = 3'd3;
    end
    len_term = sat_add(len, term_k);
    len_word = sat_add(len, 3'd4);
  end

  always_ff @(posedge I_pla_312m5_clk) begin
    if (I_pla_rst) begin
      state        <= ST_IDLE;
      len          <= 16'd0;
      err_sticky   <= 1'b0;
      O_frame_done <= 1'b0;
      O_frame_len  <= 16'd0;
      O_frame_err  <= 1'b0;
    end else begin
      O_frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_start) state <= ST_PRE;
        end
        ST_PRE: begin
          if (is_sfd) begin
            state      <= ST_DATA;
            len        <= 16'd0;
            err_sticky <= 1'b0;
          end else begin
            O_frame_done <= 1'b1;
            O_frame_len  <= 16'd0;
            O_frame_err  <= 1'b1;
            state        <= is_start ? ST_PRE : ST_IDLE;
          end
        end
        ST_DATA: begin
          if (is_data) begin
            len <= len_word;
          end else if (is_term) begin
            O_frame_done <= 1'b1;
            O_frame_len  <= len_term;
            O_frame_err  <= err_sticky | len_bad(len_term);
            state        <= ST_IDLE;
          end else if (is_start) begin
            // A new Start while a frame is open closes the old one as bad.
            O_frame_done <= 1'b1;
            O_frame_len  <= len;
            O_frame_err  <= 1'b1;
            state        <= ST_PRE;
          end else begin
            err_sticky <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Clear zeroes the counters but still applies a coincident frame event.
  always_ff @(posedge I_pla_312m5_clk) begin
    if (I_pla_rst) begin
      O_good_cnt <= 32'd0;
      O_bad_cnt  <= 32'd0;
      O_byte_cnt <= 32'd0;
    end else if (I_stat_clr) begin
      O_good_cnt <= {31'd0, O_frame_done & ~O_frame_err};
      O_bad_cnt  <= {31'd0, O_frame_done &  O_frame_err};
      O_byte_cnt <= (O_frame_done && !O_frame_err) ? {16'd0, O_frame_len} : 32'd0;
    end else if (O_frame_done) begin
      if (O_frame_err) begin
        O_bad_cnt <= O_bad_cnt + 32'd1;
      end else begin
        O_good_cnt <= O_good_cnt + 32'd1;
        O_byte_cnt <= O_byte_cnt + {16'd0, O_frame_len};
      end
    end
  end

endmodule

// File: tb/tb_f1_xgmii_frame_mon.sv
// Bench for f1_xgmii_frame_mon: directed and random frames checked against a
// frame-level model (length from word counts, error from length limits/flags).
module tb_f1_xgmii_frame_mon;

  localparam logic [31:0] IDLE_D  = 32'h07070707;
  localparam logic [31:0] START_D = 32'hFB555555;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] xd;
  logic [3:0]  xc;
  logic        clr;
  logic        done;
  logic [15:0] flen;
  logic        ferr;
  logic [31:0] good_cnt, bad_cnt, byte_cnt;

  int          checks = 0;
  int          passes = 0;
  int          good_m = 0;
  int          bad_m = 0;
  logic [31:0] byte_m = 32'd0;
  logic [16:0] evq[$];

  always #5 clk = ~clk;

  f1_xgmii_frame_mon #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .I_pla_312m5_clk(clk),
    .I_pla_rst(rst),
    .I_xgmii_d(xd),
    .I_xgmii_c(xc),
    .I_stat_clr(clr),
    .O_frame_done(done),
    .O_frame_len(flen),
    .O_frame_err(ferr),
    .O_good_cnt(good_cnt),
    .O_bad_cnt(bad_cnt),
    .O_byte_cnt(byte_cnt)
  );

  always @(negedge clk) if (done === 1'b1) evq.push_back({ferr, flen});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] c);
    @(negedge clk);
    xd = d;
    xc = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(IDLE_D, 4'hF);
  endtask

  task automatic drive_term(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      0:       drive(32'hFD070707, 4'b1111);
      1:       drive({r[31:24], 8'hFD, 16'h0707}, 4'b0111);
      2:       drive({r[31:16], 8'hFD, 8'h07}, 4'b0011);
      default: drive({r[31:8], 8'hFD}, 4'b0001);
    endcase
  endtask

  // n data words; an error-character word is inserted before data word errch_at
  task automatic send_frame(input int n, input int k, input int errch_at,
                            input bit term, input int gap);
    logic [31:0] r;
    drive(START_D, 4'b1000);
    drive(32'h555555D5, 4'b0000);
    for (int i = 0; i < n; i++) begin
      if (i == errch_at) begin
        r = $urandom;
        drive({r[31:24], 8'hFE, r[15:0]}, 4'b0100);
      end
      drive($urandom, 4'b0000);
    end
    if (term) begin
      drive_term(k);
      idle(gap);
    end
  endtask

  task automatic expect_done(input logic [15:0] l, input logic e, input string tag);
    int t;
    logic [16:0] ev;
    t = 0;
    while (evq.size() == 0 && t < 50) begin
      idle(1);
      t++;
    end
    chk({tag, "_present"}, evq.size() > 0 ? 32'd1 : 32'd0, 32'd1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      chk({tag, "_len"}, {16'd0, ev[15:0]}, {16'd0, l});
      chk({tag, "_err"}, {31'd0, ev[16]}, {31'd0, e});
    end
    if (e) bad_m++;
    else begin
      good_m++;
      byte_m += {16'd0, l};
    end
  endtask

  // Frame-level expectation: 4 bytes per data word plus trailing Terminate bytes.
  task automatic expect_frame(input int n, input int k, input bit bad_word,
                              input bit term, input string tag);
    int l;
    logic e;
    l = 4 * n + (term ? k : 0);
    if (l > 65535) l = 65535;
    e = bad_word || !term || l < 64 || l > 1518;
    expect_done(l[15:0], e, tag);
  endtask

  task automatic check_counters(input string tag);
    idle(2);
    chk({tag, "_good"}, good_cnt, good_m);
    chk({tag, "_bad"},  bad_cnt,  bad_m);
    chk({tag, "_byte"}, byte_cnt, byte_m);
  endtask

  initial begin
    int n, k, ea, gap;
    bit bw;
    rst = 1'b1;
    clr = 1'b0;
    xd  = IDLE_D;
    xc  = 4'hF;
    idle(3);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_len",  {16'd0, flen}, 32'd0);
    chk("rst_err",  {31'd0, ferr}, 32'd0);
    chk("rst_good", good_cnt, 32'd0);
    chk("rst_bad",  bad_cnt,  32'd0);
    chk("rst_byte", byte_cnt, 32'd0);
    @(negedge clk) rst = 1'b0;
    idle(2);

    send_frame(16, 0, -1, 1, 3);
    expect_frame(16, 0, 0, 1, "good64");
    check_counters("good64");

    send_frame(16, 1, -1, 1, 3);
    expect_frame(16, 1, 0, 1, "len65");
    send_frame(16, 3, -1, 1, 3);
    expect_frame(16, 3, 0, 1, "len67");
    check_counters("odd");

    send_frame(15, 0, -1, 1, 3);
    expect_frame(15, 0, 0, 1, "runt60");
    send_frame(379, 3, -1, 1, 3);
    expect_frame(379, 3, 0, 1, "giant1519");
    send_frame(379, 2, -1, 1, 3);
    expect_frame(379, 2, 0, 1, "max1518");
    check_counters("limits");

    send_frame(20, 0, -1, 0, 0);
    send_frame(16, 0, -1, 1, 3);
    expect_frame(20, 0, 0, 0, "noterm");
    expect_frame(16, 0, 0, 1, "after_noterm");
    check_counters("noterm");

    send_frame(16, 0, 5, 1, 3);
    expect_frame(16, 0, 1, 1, "errch");
    check_counters("errch");

    drive(START_D, 4'b1000);
    idle(3);
    expect_done(16'd0, 1'b1, "pre_idle");
    drive(START_D, 4'b1000);
    send_frame(16, 2, -1, 1, 3);
    expect_done(16'd0, 1'b1, "pre_start");
    expect_frame(16, 2, 0, 1, "after_pre");
    check_counters("pre");

    send_frame(16, 0, -1, 1, 0);
    @(negedge clk);
    xd = IDLE_D; xc = 4'hF; clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    good_m = 0; bad_m = 0; byte_m = 32'd0;
    expect_frame(16, 0, 0, 1, "clr_coinc");
    check_counters("clr_coinc");

    send_frame(16, 0, -1, 1, 0);
    send_frame(17, 1, -1, 1, 3);
    expect_frame(16, 0, 0, 1, "b2b_a");
    expect_frame(17, 1, 0, 1, "b2b_b");
    check_counters("b2b");

    send_frame(5, 0, -1, 0, 0);
    @(negedge clk);
    rst = 1'b1; xd = IDLE_D; xc = 4'hF;
    idle(1);
    @(negedge clk) rst = 1'b0;
    good_m = 0; bad_m = 0; byte_m = 32'd0;
    idle(3);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_len",  {16'd0, flen}, 32'd0);
    chk("mid_rst_err",  {31'd0, ferr}, 32'd0);
    chk("mid_rst_noev", evq.size(), 32'd0);
    check_counters("mid_rst");
    send_frame(16, 0, -1, 1, 3);
    expect_frame(16, 0, 0, 1, "post_rst");
    check_counters("post_rst");

    for (int i = 0; i < 30; i++) begin
      n   = $urandom_range(12, 24);
      k   = $urandom_range(0, 3);
      bw  = ($urandom_range(0, 4) == 0);
      ea  = bw ? $urandom_range(0, n - 1) : -1;
      gap = $urandom_range(0, 3);
      send_frame(n, k, ea, 1, gap);
      expect_frame(n, k, bw, 1, "rand");
      check_counters("rand");
    end

    idle(4);
    chk("no_stray_events", evq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
